// File: rtl/memory_ram_pkg.sv
// memory_ram_pkg: shared state encoding and read-during-write mode constants
package memory_ram_pkg;
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
    localparam int MODE_READ_FIRST  = 0;
    localparam int MODE_WRITE_FIRST = 1;
endpackage

// File: rtl/memory_ram_param_if.sv
// memory_ram_param_if: access and status bundle between a RAM user and the RAM
interface memory_ram_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              en;
    logic              wen;
    logic              clr;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              busy;
    modport master (output en, wen, address, din, clr, input out, out_valid, busy);
    modport slave  (input en, wen, address, din, clr, output out, out_valid, busy);
endinterface

// File: rtl/memory_ram_clear_seq.sv
// memory_ram_clear_seq: CLEAR/IDLE sequencer that zeroes the array and owns its write port mux
module memory_ram_clear_seq
    import memory_ram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_wen,
    input  logic              i_clr,
    input  logic              i_in_range,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_din,
    output logic              o_busy,
    output logic              o_accept,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;

    // State and sweep pointer; reset restarts the sweep from word 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Sweep advances one word per edge; clr in IDLE restarts it and wins over any access
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (r_state == CLEAR) begin
            w_ptr_nxt   = (r_ptr == LAST) ? '0 : r_ptr + ADDR_W'(1);
            w_state_nxt = (r_ptr == LAST) ? IDLE : CLEAR;
        end else if (i_clr) begin
            w_state_nxt = CLEAR;
            w_ptr_nxt   = '0;
        end
    end

    assign o_busy   = (r_state == CLEAR);
    assign o_accept = !o_busy && !i_clr && i_en;
    assign o_we     = o_busy || (o_accept && i_wen && i_in_range);
    assign o_waddr  = o_busy ? r_ptr : i_address;
    assign o_wdata  = o_busy ? '0 : i_din;
endmodule

// File: rtl/memory_ram_param.sv
// memory_ram_param: parametrised single-port RAM with registered output and hardware clear
module memory_ram_param
    import memory_ram_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 2 ** ADDR_W,
    parameter int WRITE_MODE = MODE_READ_FIRST
) (
    input logic               clk,
    input logic               rst_n,
    memory_ram_param_if.slave bus
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_in_range;
    logic              w_busy;
    logic              w_accept;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_out_nxt;

    assign w_in_range = 32'(bus.address) < 32'(DEPTH);

    memory_ram_clear_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (bus.en),
        .i_wen     (bus.wen),
        .i_clr     (bus.clr),
        .i_in_range(w_in_range),
        .i_address (bus.address),
        .i_din     (bus.din),
        .o_busy    (w_busy),
        .o_accept  (w_accept),
        .o_we      (w_we),
        .o_waddr   (w_waddr),
        .o_wdata   (w_wdata)
    );

    // Array write port; contents are not reset, the sweep zeroes them instead
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    assign w_rdata   = w_in_range ? r_mem[bus.address] : '0;
    assign w_out_nxt = !w_in_range ? '0 :
                       (WRITE_MODE == MODE_WRITE_FIRST && bus.wen) ? bus.din : w_rdata;

    // Output register: updates only on accepted accesses, valid pulses once per access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= w_accept;
            if (w_accept) bus.out <= w_out_nxt;
        end
    end

    assign bus.busy = w_busy;
endmodule

// File: tb/tb_memory_ram_param.sv
// tb_memory_ram_param: three RAM configurations driven in lockstep and checked against a behavioural model
module tb_memory_ram_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0, wen = 1'b0, clr = 1'b0;
    logic [3:0]  addr = '0;
    logic [15:0] din = '0;
    bit          chk_on = 1'b0;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    memory_ram_param_if #(.DATA_W(16), .ADDR_W(4)) if0 ();
    memory_ram_param_if #(.DATA_W(16), .ADDR_W(4)) if1 ();
    memory_ram_param_if #(.DATA_W(16), .ADDR_W(4)) if2 ();

    assign if0.en = en; assign if0.wen = wen; assign if0.clr = clr; assign if0.address = addr; assign if0.din = din;
    assign if1.en = en; assign if1.wen = wen; assign if1.clr = clr; assign if1.address = addr; assign if1.din = din;
    assign if2.en = en; assign if2.wen = wen; assign if2.clr = clr; assign if2.address = addr; assign if2.din = din;

    memory_ram_param #(.DATA_W(16), .ADDR_W(4), .WRITE_MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    memory_ram_param #(.DATA_W(16), .ADDR_W(4), .WRITE_MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    memory_ram_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .WRITE_MODE(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic [15:0] d_out [3];
    logic        d_val [3];
    logic        d_busy[3];
    assign d_out[0] = if0.out; assign d_val[0] = if0.out_valid; assign d_busy[0] = if0.busy;
    assign d_out[1] = if1.out; assign d_val[1] = if1.out_valid; assign d_busy[1] = if1.busy;
    assign d_out[2] = if2.out; assign d_val[2] = if2.out_valid; assign d_busy[2] = if2.busy;

    // Model: a clear is "DEPTH cycles of busy, after which every word reads 0"
    int          dep[3] = '{16, 16, 12};
    int          wf[3]  = '{0, 1, 0};
    logic [15:0] m_mem[3][16];
    logic [15:0] m_out[3];
    logic        m_val[3];
    int          m_left[3];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n || (m_left[k] == 0 && clr)) begin
                m_left[k] = dep[k];
                m_val[k]  = 1'b0;
                for (int a = 0; a < 16; a++) m_mem[k][a] = '0;
                if (!rst_n) m_out[k] = '0;
            end else if (m_left[k] > 0) begin
                m_left[k] = m_left[k] - 1;
                m_val[k]  = 1'b0;
            end else if (!en) begin
                m_val[k] = 1'b0;
            end else begin
                m_val[k] = 1'b1;
                if (int'(addr) >= dep[k]) m_out[k] = '0;
                else begin
                    m_out[k] = (wen && wf[k] == 1) ? din : m_mem[k][addr];
                    if (wen) m_mem[k][addr] = din;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("out%0d", k), int'(d_out[k]), int'(m_out[k]));
                check($sformatf("valid%0d", k), int'(d_val[k]), int'(m_val[k]));
                check($sformatf("busy%0d", k), int'(d_busy[k]), int'(m_left[k] > 0));
            end
        end
    end

    task automatic op(input logic e, input logic w, input int a, input int d);
        en = e; wen = w; addr = 4'(a); din = 16'(d);
        @(negedge clk);
    endtask

    task automatic sweep(input string nm, input int e0, input int e2);
        int c0 = 0, c2 = 0;
        for (int i = 0; i < 20; i++) begin
            c0 += int'(d_busy[0]);
            c2 += int'(d_busy[2]);
            @(negedge clk);
        end
        check({nm, "_len16"}, c0, e0);
        check({nm, "_len12"}, c2, e2);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_busy", int'(d_busy[0]), 1);
        check("rst_out", int'(d_out[0]), 0);
        check("rst_valid", int'(d_val[0]), 0);
        chk_on = 1'b1;
        rst_n = 1'b1;
        sweep("rst", 16, 12);
        for (int a = 0; a < 16; a++) op(1, 0, a, 0);
        check("rd15_out", int'(d_out[0]), 0);
        check("rd15_valid", int'(d_val[0]), 1);
        op(1, 1, 10, 25);
        op(1, 0, 5, 0);
        check("rd5", int'(d_out[0]), 0);
        op(1, 0, 10, 0);
        check("rd10", int'(d_out[0]), 25);
        check("rd10_valid", int'(d_val[0]), 1);
        op(0, 0, 0, 0);
        check("idle_valid", int'(d_val[0]), 0);
        check("idle_hold", int'(d_out[0]), 25);
        op(1, 1, 3, 'h1111);
        op(1, 1, 3, 'h2222);
        check("rdw_read_first", int'(d_out[0]), 'h1111);
        check("rdw_write_first", int'(d_out[1]), 'h2222);
        op(1, 0, 3, 0);
        check("rd3_mode0", int'(d_out[0]), 'h2222);
        check("rd3_mode1", int'(d_out[1]), 'h2222);
        op(1, 1, 13, 'h77);
        check("oor_wr_out", int'(d_out[2]), 0);
        check("oor_wr_valid", int'(d_val[2]), 1);
        op(1, 0, 13, 0);
        check("oor_rd_out", int'(d_out[2]), 0);
        check("oor_rd_valid", int'(d_val[2]), 1);
        check("inrange13_d16", int'(d_out[0]), 'h77);
        op(1, 1, 11, 'hFF);
        op(1, 0, 11, 0);
        check("rd11_d12", int'(d_out[2]), 'hFF);
        op(1, 1, 9, 'hABCD);
        en = 1'b1; wen = 1'b1; addr = 4'd2; din = 16'h5555; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; wen = 1'b0;
        sweep("clr", 16, 12);
        op(1, 0, 9, 0);
        check("clr_rd9", int'(d_out[0]), 0);
        op(1, 0, 2, 0);
        check("clr_rd2", int'(d_out[0]), 0);
        op(1, 1, 4, 'h1234);
        op(1, 0, 4, 0);
        check("pre_rst_out", int'(d_out[0]), 'h1234);
        en = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out", int'(d_out[0]), 0);
        check("mid_rst_busy", int'(d_busy[0]), 1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        sweep("rst2", 16, 12);
        op(1, 0, 4, 0);
        check("rst2_rd4", int'(d_out[0]), 0);
        op(0, 0, 0, 0);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/memory_ram_param.md
# memory_ram_param

Parametrised single-port synchronous RAM, successor to the fixed 16-bit × 16-word memory. It adds configurable width and depth, a selectable read-during-write mode, a registered output with a valid strobe, and a hardware clear sequencer that zeroes every word after reset or on request. It is the general storage primitive for lab datapaths that need a small initialised scratch memory.

## Interface
- `DATA_W`, default 16: word width in bits.
- `ADDR_W`, default 4: address width in bits.
- `DEPTH`, default 2**ADDR_W: number of words, with 1 ≤ DEPTH ≤ 2**ADDR_W.
- `WRITE_MODE`, default 0: read-during-write behaviour; 0 = read-first (old data), 1 = write-first (new data).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `en`  in  1  access enable.
- `wen`  in  1  write enable; qualified by `en`.
- `address`  in  ADDR_W  word address.
- `din`  in  DATA_W  write data.
- `clr`  in  1  clear request, sampled in IDLE only.
- `out`  out  DATA_W  registered read data.
- `out_valid`  out  1  high for one cycle after each accepted access.
- `busy`  out  1  high while a clear sweep is in progress; accesses are ignored.

## Operation
- Two states: CLEAR and IDLE.
- Reset assertion:
  - Forces CLEAR with sweep pointer 0, `out`=0, `out_valid`=0 and `busy`=1, all immediately and asynchronously.
  - The array itself has no reset.
- CLEAR:
  - Each edge writes 0 to mem[pointer] and increments the pointer.
  - The edge that writes word DEPTH-1 moves to IDLE; `busy` falls after that edge.
  - A sweep therefore takes exactly DEPTH cycles after `rst_n` rises.
  - `en`, `wen`, `clr` are ignored. `out` holds its value and `out_valid`=0.
- IDLE:
  - `clr`=1 moves to CLEAR, resets the pointer to 0 and drops any same-cycle access; `clr` has priority over `en`.
  - `en`=1, `wen`=0: read. `out` ← mem[address], `out_valid`=1.
  - `en`=1, `wen`=1: write. mem[address] ← din, `out_valid`=1.
    - `out` ← old word if WRITE_MODE=0.
    - `out` ← din if WRITE_MODE=1.
  - `en`=0: no access. `out` holds and `out_valid`=0.
- Out-of-range address (address ≥ DEPTH):
  - A write is dropped and the array is unchanged.
  - A read returns 0 with `out_valid`=1.
  - A write in this case also returns 0 on `out`, regardless of WRITE_MODE.
- Reset asserted mid-sweep restarts the sweep from word 0. A partial sweep never leaves IDLE reachable early.

## Timing
- Read latency is 1 cycle: an access sampled at edge N shows on `out` and `out_valid` after edge N.
- Back-to-back accesses are accepted every cycle, with no bubbles in IDLE.
- `out_valid` is never high while `busy`=1.
- After reset release, the first access is accepted at the first edge with `busy`=0, i.e. edge DEPTH+1 counting the first edge after `rst_n` rises as edge 1.
- The pointer width is ADDR_W bits. The terminal compare is against DEPTH-1, so non-power-of-two depths are handled correctly.

## Structure
- Package `memory_ram_pkg` holds:
  - the state enum: IDLE, CLEAR;
  - constants `MODE_READ_FIRST`=0 and `MODE_WRITE_FIRST`=1.
- Sub-module `memory_ram_clear_seq` holds the state register, sweep pointer and `busy`. It drives the array write port mux: sweep address/zero data versus user address/din.
- The top holds the array, the output register, the mode mux and the range check.

## Test plan
- **Reset and sweep** (defaults): `rst_n` low 2 cycles, then high.
  - `busy`=1 for exactly 16 cycles, then 0.
  - Reading addresses 0–15 returns 0 each, with `out_valid` pulsing each cycle.
- **Basic write/read:** write 25 to address 10, then read 5, then read 10.
  - Read 5 gives `out`=0; read 10 gives `out`=25, each one cycle after its request.
  - `out_valid`=0 while `en`=0.
- **Read-during-write:** address 3 holds 0x1111; write 0x2222 to it.
  - WRITE_MODE=0: `out`=0x1111.
  - WRITE_MODE=1: `out`=0x2222.
  - A later read of address 3 gives 0x2222 in both modes.
- **Clear request:** write 0xABCD to address 9, then pulse `clr` with `en`=1, `wen`=1, address 2, din 0x5555 in the same cycle.
  - Address 2 is not written.
  - `busy` is high for 16 cycles, and `en` is ignored throughout.
  - Afterwards, reads of addresses 9 and 2 both return 0.
- **Reset mid-sweep:** assert `rst_n` low when the pointer is 7.
  - `out`=0 and `busy`=1 immediately.
  - After release the sweep takes the full 16 cycles.
- **Non-power-of-two depth** (DEPTH=12, ADDR_W=4):
  - Sweep lasts 12 cycles.
  - Write to address 13 is dropped; reading 13 gives 0 with `out_valid`=1.
  - Write/read at address 11 round-trips 0x00FF.
